// File: rtl/sound_event_sequencer_if.sv
// Event/control bundle between the game logic, the sound event sequencer and the audio player.
interface sound_event_sequencer_if;
   logic       hit_evt;
   logic       score_evt;
   logic       win_evt;
   logic       mute_sw;
   logic [1:0] music_sel;
   logic       audio_rst;
   logic       audio_mute;
   logic       busy;

   modport master (
      output hit_evt, score_evt, win_evt, mute_sw,
      input  music_sel, audio_rst, audio_mute, busy
   );

   modport slave (
      input  hit_evt, score_evt, win_evt, mute_sw,
      output music_sel, audio_rst, audio_mute, busy
   );
endinterface

// File: rtl/sound_event_sequencer.sv
// Queues hit/score/win sound events and drives the audio player so each track plays once, then a gap.
// Optional: define SND_WIN_PREEMPT_EN to let a win event abort a playing hit or score track.
module sound_event_sequencer #(
   parameter int unsigned NOTE_CYCLES = 4194304,
   parameter int unsigned HIT_NOTES   = 1,
   parameter int unsigned SCORE_NOTES = 3,
   parameter int unsigned WIN_NOTES   = 11,
   parameter int unsigned GAP_CYCLES  = 1048576
) (
   input  logic                   clk,
   input  logic                   rst,
   sound_event_sequencer_if.slave bus
);
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned FLAG_W = 3;

   localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_NOTES * NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_NOTES * NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_NOTES * NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   localparam logic [SEL_W-1:0] SEL_HIT   = 2'd0;
   localparam logic [SEL_W-1:0] SEL_SCORE = 2'd1;
   localparam logic [SEL_W-1:0] SEL_WIN   = 2'd2;

   typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_e;

   state_e              state_q, state_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;     // bit index equals the track's music_sel code
   logic [SEL_W-1:0]    music_sel_q, music_sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                audio_rst_q, audio_rst_d;

   logic [SEL_W-1:0]    pick_sel_c;
   logic [FLAG_W-1:0]   pick_mask_c;
   logic [FLAG_W-1:0]   set_c;
   logic [FLAG_W-1:0]   clr_c;
   logic [CNT_W-1:0]    len_last_c;
   logic                preempt_c;

   // Priority pick win > score > hit among pending flags
   always_comb begin
      pick_sel_c = SEL_HIT;
      if (flags_q[SEL_WIN]) begin
         pick_sel_c = SEL_WIN;
      end else if (flags_q[SEL_SCORE]) begin
         pick_sel_c = SEL_SCORE;
      end
      pick_mask_c = FLAG_W'(1) << pick_sel_c;
   end

   always_comb begin
      case (music_sel_q)
         SEL_WIN:   len_last_c = WIN_LAST;
         SEL_SCORE: len_last_c = SCORE_LAST;
         default:   len_last_c = HIT_LAST;
      endcase
   end

   always_comb begin
`ifdef SND_WIN_PREEMPT_EN
      preempt_c = bus.win_evt && !bus.mute_sw && (music_sel_q != SEL_WIN) &&
                  ((state_q == PLAY) || (state_q == GAP));
`else
      preempt_c = 1'b0;
`endif
   end

   // Next-state, counter, flag and output logic
   always_comb begin
      state_d     = state_q;
      music_sel_d = music_sel_q;
      cnt_d       = cnt_q;
      clr_c       = '0;

      case (state_q)
         IDLE: begin
            if (|flags_q) begin
               state_d     = START;
               music_sel_d = pick_sel_c;
               clr_c       = pick_mask_c;
            end
         end
         START: begin
            state_d = PLAY;
            cnt_d   = len_last_c;
         end
         PLAY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (GAP_CYCLES != 0) begin
               state_d = GAP;
               cnt_d   = GAP_LAST;
            end else if (|flags_q) begin
               state_d     = START;
               music_sel_d = pick_sel_c;
               clr_c       = pick_mask_c;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (|flags_q) begin
               state_d     = START;
               music_sel_d = pick_sel_c;
               clr_c       = pick_mask_c;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A preempting win is consumed directly rather than queued
      if (preempt_c) begin
         state_d     = START;
         music_sel_d = SEL_WIN;
         clr_c       = FLAG_W'(1) << SEL_WIN;
      end

      set_c       = {bus.win_evt && !preempt_c, bus.score_evt, bus.hit_evt} & {FLAG_W{!bus.mute_sw}};
      flags_d     = (flags_q & ~clr_c) | set_c;
      audio_rst_d = (state_d == START);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         flags_q     <= '0;
         music_sel_q <= SEL_HIT;
         cnt_q       <= '0;
         audio_rst_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         flags_q     <= flags_d;
         music_sel_q <= music_sel_d;
         cnt_q       <= cnt_d;
         audio_rst_q <= audio_rst_d;
      end
   end

   assign bus.music_sel  = music_sel_q;
   assign bus.audio_rst  = audio_rst_q;
   assign bus.audio_mute = bus.mute_sw || (state_q != PLAY);
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer with NOTE_CYCLES=4, GAP_CYCLES=2; build with SND_WIN_PREEMPT_EN for the preempt variant.
module tb_sound_event_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_chk  = 0;

   sound_event_sequencer_if sif ();

   sound_event_sequencer #(
      .NOTE_CYCLES (4),
      .HIT_NOTES   (1),
      .SCORE_NOTES (3),
      .WIN_NOTES   (11),
      .GAP_CYCLES  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic expect_start(input logic [1:0] sel);
      step();
      check("start_rst",  32'(sif.audio_rst), 32'd1);
      check("start_sel",  32'(sif.music_sel), 32'(sel));
      check("start_mute", 32'(sif.audio_mute), 32'd1);
      check("start_busy", 32'(sif.busy), 32'd1);
   endtask

   task automatic expect_body(input logic [1:0] sel, input int len);
      for (int i = 0; i < len; i++) begin
         step();
         check("play_mute", 32'(sif.audio_mute), 32'd0);
         check("play_rst",  32'(sif.audio_rst), 32'd0);
         check("play_sel",  32'(sif.music_sel), 32'(sel));
      end
      for (int i = 0; i < 2; i++) begin
         step();
         check("gap_mute", 32'(sif.audio_mute), 32'd1);
         check("gap_busy", 32'(sif.busy), 32'd1);
         check("gap_rst",  32'(sif.audio_rst), 32'd0);
      end
   endtask

   task automatic expect_idle();
      step();
      check("idle_busy", 32'(sif.busy), 32'd0);
      check("idle_mute", 32'(sif.audio_mute), 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      sif.hit_evt   = 1'b0;
      sif.score_evt = 1'b0;
      sif.win_evt   = 1'b0;
      sif.mute_sw   = 1'b0;

      // Reset values and release
      step();
      step();
      check("rst_audio_rst", 32'(sif.audio_rst), 32'd1);
      check("rst_sel",       32'(sif.music_sel), 32'd0);
      check("rst_mute",      32'(sif.audio_mute), 32'd1);
      check("rst_busy",      32'(sif.busy), 32'd0);
      rst = 1'b0;
      step();
      check("rel_audio_rst", 32'(sif.audio_rst), 32'd0);
      check("rel_busy",      32'(sif.busy), 32'd0);
      check("rel_mute",      32'(sif.audio_mute), 32'd1);
      expect_idle();

      // Single hit: flag at edge k, START at k+1, 4 play cycles, 2 gap cycles
      sif.hit_evt = 1'b1;
      step();
      sif.hit_evt = 1'b0;
      check("hit_k_busy", 32'(sif.busy), 32'd0);
      expect_start(2'd0);
      expect_body(2'd0, 4);
      expect_idle();

      // Simultaneous events: win, score, hit back to back
      sif.hit_evt   = 1'b1;
      sif.score_evt = 1'b1;
      sif.win_evt   = 1'b1;
      step();
      sif.hit_evt   = 1'b0;
      sif.score_evt = 1'b0;
      sif.win_evt   = 1'b0;
      expect_start(2'd2);
      expect_body(2'd2, 44);
      expect_start(2'd1);
      expect_body(2'd1, 12);
      expect_start(2'd0);
      expect_body(2'd0, 4);
      expect_idle();

      // Muted event is dropped
      sif.mute_sw   = 1'b1;
      sif.score_evt = 1'b1;
      step();
      sif.score_evt = 1'b0;
      sif.mute_sw   = 1'b0;
      check("muted_busy0", 32'(sif.busy), 32'd0);
      expect_idle();
      expect_idle();

      // Mute raised during PLAY: immediate mute, unchanged length
      sif.hit_evt = 1'b1;
      step();
      sif.hit_evt = 1'b0;
      expect_start(2'd0);
      step();
      check("mplay_c1_mute", 32'(sif.audio_mute), 32'd0);
      sif.mute_sw = 1'b1;
      #1;
      check("mplay_imm_mute", 32'(sif.audio_mute), 32'd1);
      step();
      check("mplay_c2_mute", 32'(sif.audio_mute), 32'd1);
      check("mplay_c2_busy", 32'(sif.busy), 32'd1);
      step();
      check("mplay_c3_mute", 32'(sif.audio_mute), 32'd1);
      sif.mute_sw = 1'b0;
      #1;
      check("mplay_unmute", 32'(sif.audio_mute), 32'd0);
      step();
      check("mplay_c4_mute", 32'(sif.audio_mute), 32'd0);
      step();
      check("mplay_gap_mute", 32'(sif.audio_mute), 32'd1);
      check("mplay_gap_busy", 32'(sif.busy), 32'd1);
      step();
      check("mplay_gap2_busy", 32'(sif.busy), 32'd1);
      expect_idle();

      // Win arrives 5 cycles into a score track
      sif.score_evt = 1'b1;
      step();
      sif.score_evt = 1'b0;
      expect_start(2'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("pre_score_mute", 32'(sif.audio_mute), 32'd0);
      end
      sif.win_evt = 1'b1;
      step();
      sif.win_evt = 1'b0;
`ifdef SND_WIN_PREEMPT_EN
      check("preempt_rst",  32'(sif.audio_rst), 32'd1);
      check("preempt_sel",  32'(sif.music_sel), 32'd2);
      check("preempt_mute", 32'(sif.audio_mute), 32'd1);
      expect_body(2'd2, 44);
      expect_idle();
`else
      check("nopre_c6_sel",  32'(sif.music_sel), 32'd1);
      check("nopre_c6_mute", 32'(sif.audio_mute), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("nopre_play_sel",  32'(sif.music_sel), 32'd1);
         check("nopre_play_mute", 32'(sif.audio_mute), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         check("nopre_gap_mute", 32'(sif.audio_mute), 32'd1);
         check("nopre_gap_rst",  32'(sif.audio_rst), 32'd0);
      end
      expect_start(2'd2);
      expect_body(2'd2, 44);
      expect_idle();
`endif

      // Reset mid-PLAY with hit pending aborts and clears flags
      sif.score_evt = 1'b1;
      step();
      sif.score_evt = 1'b0;
      expect_start(2'd1);
      step();
      sif.hit_evt = 1'b1;
      step();
      sif.hit_evt = 1'b0;
      check("midrst_play_mute", 32'(sif.audio_mute), 32'd0);
      rst = 1'b1;
      step();
      check("midrst_busy",      32'(sif.busy), 32'd0);
      check("midrst_audio_rst", 32'(sif.audio_rst), 32'd1);
      check("midrst_mute",      32'(sif.audio_mute), 32'd1);
      check("midrst_sel",       32'(sif.music_sel), 32'd0);
      rst = 1'b0;
      step();
      check("postrst_audio_rst", 32'(sif.audio_rst), 32'd0);
      check("postrst_busy",      32'(sif.busy), 32'd0);
      expect_idle();
      expect_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
